// File: rtl/d_flip_flop_pkg.sv
// Shared constants and control-priority types for the d_flip_flop register family.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   DFF_RESET_BIT - per-bit default reset value, replicated to WIDTH by users
//   ctrl_e        - the action a stage takes at a rising edge, highest priority first
//   ctrl_decode   - maps rst/clr/set/en to the winning ctrl_e action
package d_flip_flop_pkg;

  localparam logic DFF_RESET_BIT = 1'b0;

  typedef enum logic [2:0] {
    CTRL_RST  = 3'd0,
    CTRL_CLR  = 3'd1,
    CTRL_SET  = 3'd2,
    CTRL_LOAD = 3'd3,
    CTRL_HOLD = 3'd4
  } ctrl_e;

  // rst beats clr beats set beats en; with nothing asserted the stage holds.
  function automatic ctrl_e ctrl_decode(input logic rst, input logic clr,
                                        input logic set, input logic en);
    ctrl_e c;
    if (rst)      c = CTRL_RST;
    else if (clr) c = CTRL_CLR;
    else if (set) c = CTRL_SET;
    else if (en)  c = CTRL_LOAD;
    else          c = CTRL_HOLD;
    return c;
  endfunction

endpackage

// File: rtl/d_flip_flop_if.sv
// Data/control bundle for d_flip_flop: input word, controls and true/complement outputs.
// Latency: none (wires only).
// Backpressure: none; the register accepts a new word on every enabled edge.
//
// Signals:
//   en, clr, set - capture enable, synchronous clear, synchronous set
//   d            - WIDTH-bit data input
//   q, qb        - registered data and its bitwise complement
// Modports: master drives en/clr/set/d and observes q/qb; slave is the register.
interface d_flip_flop_if #(
  parameter int WIDTH = 1
);

  logic             en;
  logic             clr;
  logic             set;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;

  modport master (
    output en, clr, set, d,
    input  q, qb
  );

  modport slave (
    input  en, clr, set, d,
    output q, qb
  );

endinterface

// File: rtl/d_flip_flop_dff_stage.sv
// Single WIDTH-bit rising-edge register stage with sync reset, clear, set and enable.
// Latency: 1 clk from d to q when enabled.
// Backpressure: none; en=0 simply holds the current value.
//
// Ports:
//   clk       - clock, all updates on the rising edge
//   rst       - synchronous active-high reset, loads RESET_VAL
//   clr, set  - synchronous clear to zeros / set to ones (clr wins over set)
//   en        - capture enable
//   d, q      - data in / registered data out
module dff_stage #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             set,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Order of the if-chain is the control priority: rst, clr, set, en.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= '0;
    end else if (set) begin
      q <= '1;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_flip_flop.sv
// Parameterised D-type register chain of STAGES dff_stage instances with true and complement outputs.
// Latency: STAGES clk edges from d to q while en is held high.
// Backpressure: none; en=0 freezes every stage together, so in-flight data is never lost or skipped.
//
// Ports:
//   clk - clock, rising edge only
//   rst - synchronous active-high reset, every stage loads RESET_VAL
//   bus - d_flip_flop_if slave: en/clr/set/d in, q/qb out
// STAGES must be at least 1.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_RESET_BIT}}
) (
  input  logic          clk,
  input  logic          rst,
  d_flip_flop_if.slave  bus
);

  // chain[0] is the data input; chain[k] is the output of stage k-1.
  logic [STAGES:0][WIDTH-1:0] chain;

  assign chain[0] = bus.d;

  // Every stage shares the same controls, so clr/set/rst hit the whole
  // chain on one edge and en stalls it as a unit.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (bus.clr),
      .set (bus.set),
      .en  (bus.en),
      .d   (chain[k]),
      .q   (chain[k+1])
    );
  end

  // Both outputs derive only from the last register, so d has no path to qb.
  assign bus.q  = chain[STAGES];
  assign bus.qb = ~chain[STAGES];

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench for d_flip_flop: three configurations driven in lockstep,
// expectations from a history-based model, compared by a free-running monitor.
module tb_d_flip_flop;
  import d_flip_flop_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  d_flip_flop_if #(.WIDTH(1)) if1 ();
  d_flip_flop_if #(.WIDTH(4)) if4 ();
  d_flip_flop_if #(.WIDTH(8)) if8 ();

  d_flip_flop #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave));
  d_flip_flop #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'h9)) u_dut4 (
    .clk (clk), .rst (rst), .bus (if4.slave));
  d_flip_flop #(.WIDTH(8), .STAGES(3)) u_dut8 (
    .clk (clk), .rst (rst), .bus (if8.slave));

  int checks = 0;
  int errors = 0;

  // Model: every value that enters a chain is appended to its history; a
  // whole-chain fill (rst/clr/set) appends enough copies to flush it. After
  // an edge, q is the entry STAGES back from the newest.
  logic [7:0] h1[$];
  logic [7:0] h4[$];
  logic [7:0] h8[$];
  logic       exp1[$];
  logic [3:0] exp4[$];
  logic [7:0] exp8[$];

  function automatic logic [7:0] fill_val(input ctrl_e c, input logic [7:0] rv,
                                          input logic [7:0] ones);
    logic [7:0] v;
    v = 8'h00;
    if (c == CTRL_RST)      v = rv;
    else if (c == CTRL_SET) v = ones;
    return v;
  endfunction

  task automatic advance(input ctrl_e c, input logic d1v, input logic [3:0] d4v,
                         input logic [7:0] d8v);
    if (c == CTRL_RST || c == CTRL_CLR || c == CTRL_SET) begin
      for (int k = 0; k < 3; k++) begin
        h1.push_back(fill_val(c, 8'h00, 8'h01));
        h4.push_back(fill_val(c, 8'h09, 8'h0F));
        h8.push_back(fill_val(c, 8'h00, 8'hFF));
      end
    end else if (c == CTRL_LOAD) begin
      h1.push_back({7'd0, d1v});
      h4.push_back({4'd0, d4v});
      h8.push_back(d8v);
    end
    while (h1.size() > 8) void'(h1.pop_front());
    while (h4.size() > 8) void'(h4.pop_front());
    while (h8.size() > 8) void'(h8.pop_front());
    begin
      logic [7:0] t1, t4;
      t1 = h1[h1.size()-1];
      t4 = h4[h4.size()-2];
      exp1.push_back(t1[0]);
      exp4.push_back(t4[3:0]);
      exp8.push_back(h8[h8.size()-3]);
    end
  endtask

  // Inputs change 2 time units after the edge, well before the monitor's
  // falling-edge sample, so each sample also confirms d alone moves nothing.
  task automatic step(input logic r, input logic c, input logic s, input logic e,
                      input logic d1v, input logic [3:0] d4v, input logic [7:0] d8v);
    #2;
    rst = r;
    if1.clr = c; if1.set = s; if1.en = e; if1.d = d1v;
    if4.clr = c; if4.set = s; if4.en = e; if4.d = d4v;
    if8.clr = c; if8.set = s; if8.en = e; if8.d = d8v;
    @(posedge clk);
    advance(ctrl_decode(r, c, s, e), d1v, d4v, d8v);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per
  // DUT at each falling edge once the scoreboard has something queued.
  initial begin
    forever begin
      @(negedge clk);
      if (exp1.size() > 0) begin
        logic e1;
        e1 = exp1.pop_front();
        check("w1_q",  {7'd0, if1.q},  {7'd0, e1});
        check("w1_qb", {7'd0, if1.qb}, {7'd0, ~e1});
      end
      if (exp4.size() > 0) begin
        logic [3:0] e4;
        e4 = exp4.pop_front();
        check("w4_q",  {4'd0, if4.q},  {4'd0, e4});
        check("w4_qb", {4'd0, if4.qb}, {4'd0, ~e4});
      end
      if (exp8.size() > 0) begin
        logic [7:0] e8;
        e8 = exp8.pop_front();
        check("w8_q",  if8.q,  e8);
        check("w8_qb", if8.qb, ~e8);
      end
    end
  end

  initial begin
    if1.en = 1'b1; if1.clr = 1'b0; if1.set = 1'b0; if1.d = '0;
    if4.en = 1'b1; if4.clr = 1'b0; if4.set = 1'b0; if4.d = '0;
    if8.en = 1'b1; if8.clr = 1'b0; if8.set = 1'b0; if8.d = '0;
    @(posedge clk);

    // Reset, then basic capture: 1 then 0; wide chain gets A5, 3C, 0F.
    step(1, 0, 0, 1, 1'b1, 4'h6, 8'h77);
    step(0, 0, 0, 1, 1'b1, 4'h1, 8'hA5);
    step(0, 0, 0, 1, 1'b0, 4'h2, 8'h3C);
    step(0, 0, 0, 1, 1'b1, 4'h3, 8'h0F);
    step(0, 0, 0, 1, 1'b1, 4'h4, 8'h11);
    step(0, 0, 0, 1, 1'b0, 4'h5, 8'h22);

    // Reset with d=1, then release and load.
    step(1, 0, 0, 1, 1'b1, 4'hE, 8'hEE);
    step(0, 0, 0, 1, 1'b1, 4'hA, 8'h5A);

    // Enable hold for three edges, then resume.
    step(0, 0, 0, 0, 1'b0, 4'h0, 8'h00);
    step(0, 0, 0, 0, 1'b0, 4'h0, 8'h00);
    step(0, 0, 0, 0, 1'b0, 4'h0, 8'h00);
    step(0, 0, 0, 1, 1'b0, 4'h7, 8'hC3);

    // Priority: clr+set, set alone, rst+set, then clr alone after data.
    step(0, 1, 1, 1, 1'b1, 4'hF, 8'hFF);
    step(0, 0, 1, 1, 1'b0, 4'h0, 8'h00);
    step(1, 0, 1, 1, 1'b1, 4'hF, 8'hFF);
    step(0, 0, 0, 1, 1'b1, 4'hB, 8'h96);
    step(0, 1, 0, 1, 1'b1, 4'hC, 8'h69);

    // Mid-stream reset with data in flight in the deeper chains.
    step(0, 0, 0, 1, 1'b1, 4'h1, 8'hD1);
    step(0, 0, 0, 1, 1'b0, 4'h2, 8'hD2);
    step(1, 0, 0, 1, 1'b1, 4'h3, 8'hD3);
    step(0, 0, 0, 1, 1'b1, 4'h4, 8'hD4);
    step(0, 0, 0, 1, 1'b0, 4'h5, 8'hD5);
    step(0, 0, 0, 1, 1'b1, 4'h6, 8'hD6);

    // Randomised traffic: mostly loads, occasional holds and overrides.
    for (int i = 0; i < 300; i++) begin
      logic r, c, s, e;
      logic [7:0] rd;
      r  = ($urandom_range(0, 15) == 0);
      c  = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      rd = 8'($urandom);
      step(r, c, s, e, rd[0], rd[7:4], 8'($urandom));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp1.size() != 0 || exp4.size() != 0 || exp8.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d/%0d pending want 0", exp1.size(), exp4.size(),
               exp8.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
- Parameterised, positive-edge-triggered D-type storage register with true and complementary outputs.
- Default configuration: a single-bit DFF (WIDTH=1, STAGES=1). Captures d on each rising clk edge and holds it between edges.
- Used as the basic state element for the flip-flop exercises and wherever a registered signal plus its inverse is needed.
- Optional enable, synchronous clear/set, and an optional multi-stage chain for delay lines or synchronisers.

Parameters:
- WIDTH, 1, bit width of d, q and qb.
- STAGES, 1, number of cascaded register stages from d to q (≥1); latency in clk cycles.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every stage on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge only.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; tie 1 for plain DFF behaviour.
- clr  input  1  synchronous clear of all stages to all-zeros.
- set  input  1  synchronous set of all stages to all-ones.
- d  input  WIDTH  data input.
- q  output  WIDTH  registered data (output of last stage).
- qb  output  WIDTH  bitwise complement of q.

Behaviour:
- One clock and one reset, named clk and rst; reset is synchronous and active-high.
- All stages update only on the rising edge of clk; nothing changes on the falling edge or while clk is level.
- Priority at each rising edge, highest first: rst, clr, set, en.
  - rst=1: all stages load RESET_VAL. q=RESET_VAL and qb=~RESET_VAL after that edge.
  - clr=1 (rst=0): all stages load 0.
  - set=1 (rst=0, clr=0): all stages load all-ones.
  - clr=1 and set=1 together: clr wins.
  - en=1 (no rst/clr/set): stage0 <= d; stage k <= stage k-1; the chain shifts.
  - en=0 (no rst/clr/set): all stages hold.
- Latency: with en held at 1, q equals d sampled STAGES rising edges earlier. With STAGES=1, q reflects d captured at the most recent edge.
- qb is always exactly ~q, combinational from the registered value. No glitch-path from d.
- Power-up before the first reset edge: outputs are undefined. Benches must reset, or clock with en=1 for STAGES edges, before checking.
- Reset asserted mid-operation: takes effect at the next rising edge and discards all in-flight stage contents.
- d changes between edges: no effect on q until the next rising edge.

Decomposition:
- Shared package: the default RESET_VAL constant, plus a control-priority enum (CTRL_RST, CTRL_CLR, CTRL_SET, CTRL_LOAD, CTRL_HOLD) used by the bench scoreboard.
- One natural sub-module, dff_stage: a single WIDTH-bit register with rst/clr/set/en and parameter RESET_VAL.
- d_flip_flop generates STAGES instances of dff_stage, chains them, and drives qb = ~q.

Test Plan:
- WIDTH=1, STAGES=1, en=1. Reset, then clk low with d=1; at the rising edge with d=1 -> q=1, qb=0. Drive clk low with d=0 -> q stays 1, qb stays 0. At the next rising edge with d=0 -> q=0, qb=1.
- Reset: rst=1 for one edge with d=1 -> q=RESET_VAL (0), qb=1. Release rst -> next edge loads d.
- Enable hold: q=1, then en=0 with d=0 for 3 edges -> q stays 1. Set en=1 -> q=0 at the next edge.
- Priority: clr=1, set=1, d=1 -> q=0. Then set=1 alone -> q=all-ones. Then rst=1 with set=1 -> q=RESET_VAL.
- WIDTH=8, STAGES=3: drive d=8'hA5, 8'h3C, 8'h0F on successive edges -> q shows 8'hA5 on the 3rd edge after the first drive, 8'h3C on the 4th, 8'h0F on the 5th. qb=~q throughout.
- Mid-stream reset with STAGES=3: assert rst while data is in flight -> q=RESET_VAL on the next edge. Pre-reset data never appears afterwards.
